// File: rtl/matmul_mem_ctrl.sv
// Single-port word memory behind the matmul engine, with a lower-priority host port,
// a fixed-latency tagged read pipeline and access statistics.
module matmul_mem_ctrl #(
  parameter int unsigned MEM_AW     = 16,
  parameter int unsigned MEM_DW     = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  // engine port
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  // host port
  input  logic              host_req,
  input  logic              host_write,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [MEM_DW-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rdata_vld,
  output logic [MEM_DW-1:0] host_rdata,
  // statistics
  input  logic              clr_stats,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  output logic [15:0]       conflict_cnt
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned Last  = RD_LAT - 1;

  logic                  acc_vld;
  logic                  acc_write;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [MEM_DW-1:0]     acc_wdata;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  conflict;

  logic [MEM_DW-1:0] storage [Depth];

  logic [RD_LAT-1:0] pipe_vld_q;
  logic [RD_LAT-1:0] pipe_host_q;
  logic [MEM_DW-1:0] pipe_data_q [RD_LAT];

  logic [MEM_DW-1:0] mem_hold_q;
  logic [MEM_DW-1:0] host_hold_q;

  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Engine always wins; the host only sees a grant in cycles the engine is quiet.
  always_comb begin
    host_gnt  = host_req && !mem_req;
    acc_vld   = mem_req || host_req;
    acc_write = mem_req ? mem_write : host_write;
    acc_idx   = mem_req ? mem_addr[DEPTH_LOG2-1:0] : host_addr[DEPTH_LOG2-1:0];
    acc_wdata = mem_req ? mem_wdata : host_wdata;
    rd_fire   = acc_vld && !acc_write;
    wr_fire   = acc_vld && acc_write;
    conflict  = mem_req && host_req;
  end

  if (MEM_AW > DEPTH_LOG2) begin : g_unused_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[MEM_AW-1:DEPTH_LOG2], host_addr[MEM_AW-1:DEPTH_LOG2]};
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      storage[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q  <= '0;
      pipe_host_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_data_q[k] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= rd_fire;
      pipe_host_q[0] <= rd_fire && !mem_req;
      pipe_data_q[0] <= storage[acc_idx];
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_vld_q[k]  <= pipe_vld_q[k-1];
        pipe_host_q[k] <= pipe_host_q[k-1];
        pipe_data_q[k] <= pipe_data_q[k-1];
      end
    end
  end

  always_comb begin
    mem_rdata_vld  = pipe_vld_q[Last] && !pipe_host_q[Last];
    host_rdata_vld = pipe_vld_q[Last] && pipe_host_q[Last];
    mem_rdata      = mem_rdata_vld ? pipe_data_q[Last] : mem_hold_q;
    host_rdata     = host_rdata_vld ? pipe_data_q[Last] : host_hold_q;
  end

  // Hold registers keep rdata stable between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_hold_q  <= '0;
      host_hold_q <= '0;
    end else begin
      if (mem_rdata_vld) begin
        mem_hold_q <= pipe_data_q[Last];
      end
      if (host_rdata_vld) begin
        host_hold_q <= pipe_data_q[Last];
      end
    end
  end

  always_comb begin
    rd_cnt_d       = rd_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (clr_stats) begin
      rd_cnt_d       = '0;
      wr_cnt_d       = '0;
      conflict_cnt_d = '0;
    end else begin
      if (rd_fire) begin
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
      if (wr_fire) begin
        wr_cnt_d = wr_cnt_q + 32'd1;
      end
      if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q       <= '0;
      wr_cnt_q       <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rd_cnt_q       <= rd_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign rd_cnt       = rd_cnt_q;
  assign wr_cnt       = wr_cnt_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_matmul_mem_ctrl.sv
// Scoreboard bench for matmul_mem_ctrl: directed scenarios followed by randomized traffic
// checked against an array/queue reference model.
module tb_matmul_mem_ctrl;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned DL  = 10;
  localparam int unsigned LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          mem_req;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rdata_vld;
  logic [DW-1:0] mem_rdata;
  logic          host_req;
  logic          host_write;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rdata_vld;
  logic [DW-1:0] host_rdata;
  logic          clr_stats;
  logic [31:0]   rd_cnt;
  logic [31:0]   wr_cnt;
  logic [15:0]   conflict_cnt;

  matmul_mem_ctrl #(
    .MEM_AW    (AW),
    .MEM_DW    (DW),
    .DEPTH_LOG2(DL),
    .RD_LAT    (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata_vld (mem_rdata_vld),
    .mem_rdata     (mem_rdata),
    .host_req      (host_req),
    .host_write    (host_write),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_gnt      (host_gnt),
    .host_rdata_vld(host_rdata_vld),
    .host_rdata    (host_rdata),
    .clr_stats     (clr_stats),
    .rd_cnt        (rd_cnt),
    .wr_cnt        (wr_cnt),
    .conflict_cnt  (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: word array plus expected read queues (data, observation cycle).
  logic [DW-1:0] model [2**DL];
  int unsigned   m_rd = 0;
  int unsigned   m_wr = 0;
  int unsigned   m_cf = 0;
  logic [DW-1:0] eq_mem[$];
  logic [DW-1:0] eq_host[$];
  int unsigned   et_mem[$];
  int unsigned   et_host[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rdata_vld || host_rdata_vld) begin
        checks++;
        if (mem_rdata_vld && host_rdata_vld) begin
          errors++;
          $display("FAIL both_vld: mem_vld=%b host_vld=%b required not both", mem_rdata_vld,
                   host_rdata_vld);
        end
      end
      if (mem_rdata_vld) begin
        checks++;
        if (eq_mem.size() == 0) begin
          errors++;
          $display("FAIL mem_rd: unexpected vld data=%h cyc=%0d", mem_rdata, cyc);
        end else begin
          logic [DW-1:0] d;
          int unsigned   t;
          d = eq_mem.pop_front();
          t = et_mem.pop_front();
          if (mem_rdata !== d || cyc != t) begin
            errors++;
            $display("FAIL mem_rd: got %h at cyc %0d, required %h at cyc %0d", mem_rdata, cyc,
                     d, t);
          end
        end
      end
      if (host_rdata_vld) begin
        checks++;
        if (eq_host.size() == 0) begin
          errors++;
          $display("FAIL host_rd: unexpected vld data=%h cyc=%0d", host_rdata, cyc);
        end else begin
          logic [DW-1:0] d;
          int unsigned   t;
          d = eq_host.pop_front();
          t = et_host.pop_front();
          if (host_rdata !== d || cyc != t) begin
            errors++;
            $display("FAIL host_rd: got %h at cyc %0d, required %h at cyc %0d", host_rdata,
                     cyc, d, t);
          end
        end
      end
    end
  end

  task automatic serve(input logic is_host, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    logic [DL-1:0] idx;
    idx = a[DL-1:0];
    if (w) begin
      model[idx] = d;
      m_wr++;
    end else begin
      if (is_host) begin
        eq_host.push_back(model[idx]);
        et_host.push_back(cyc + LAT);
      end else begin
        eq_mem.push_back(model[idx]);
        et_mem.push_back(cyc + LAT);
      end
      m_rd++;
    end
  endtask

  // Drives one cycle of inputs at the falling edge; the access is taken at the next rising edge.
  task automatic step(input logic mr, input logic mw, input logic [AW-1:0] ma,
                      input logic [DW-1:0] md, input logic hr, input logic hw,
                      input logic [AW-1:0] ha, input logic [DW-1:0] hd, input logic clr);
    logic exp_gnt;
    @(negedge clk);
    mem_req    = mr;
    mem_write  = mw;
    mem_addr   = ma;
    mem_wdata  = md;
    host_req   = hr;
    host_write = hw;
    host_addr  = ha;
    host_wdata = hd;
    clr_stats  = clr;
    #1;
    exp_gnt = hr && !mr;
    checks++;
    if (host_gnt !== exp_gnt) begin
      errors++;
      $display("FAIL host_gnt: got %b required %b (mem_req=%b host_req=%b)", host_gnt, exp_gnt,
               mr, hr);
    end
    if (mr) serve(1'b0, mw, ma, md);
    else if (hr) serve(1'b1, hw, ha, hd);
    if (mr && hr && m_cf < 32'h0000FFFF) m_cf++;
    if (clr) begin
      m_rd = 0;
      m_wr = 0;
      m_cf = 0;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic eng(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1, w, a, d, 0, 0, '0, '0, 0);
  endtask

  task automatic hst(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(0, 0, '0, '0, 1, w, a, d, 0);
  endtask

  task automatic check_cnt(input string name);
    #2;
    checks++;
    if (rd_cnt !== m_rd || wr_cnt !== m_wr || conflict_cnt !== m_cf[15:0]) begin
      errors++;
      $display("FAIL cnt_%s: rd/wr/cf got %0d/%0d/%0d required %0d/%0d/%0d", name, rd_cnt,
               wr_cnt, conflict_cnt, m_rd, m_wr, m_cf);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] r;
    r = {6'($urandom_range(0, 63)), 10'($urandom_range(0, 15))};
    return r;
  endfunction

  initial begin
    logic          mr;
    logic          hp;
    logic          hw_r;
    logic [AW-1:0] ha_r;
    logic [DW-1:0] hd_r;
    int            wait_cnt;

    rst_n      = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    host_req   = 1'b0;
    host_write = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    clr_stats  = 1'b0;
    for (int i = 0; i < 2**DL; i++) model[i] = '0;
    #22;
    checks++;
    if (mem_rdata_vld !== 1'b0 || host_rdata_vld !== 1'b0 || mem_rdata !== '0 ||
        host_rdata !== '0) begin
      errors++;
      $display("FAIL reset_out: vld %b/%b rdata %h/%h required all 0", mem_rdata_vld,
               host_rdata_vld, mem_rdata, host_rdata);
    end
    check_cnt("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Host preload and host read-back.
    hst(1, 16'd0, 32'h11);
    hst(1, 16'd1, 32'h22);
    hst(1, 16'd2, 32'h33);
    check_cnt("host_wr");
    hst(0, 16'd1, '0);
    idle(3);

    // Engine back-to-back reads return contiguously.
    eng(0, 16'd0, '0);
    eng(0, 16'd1, '0);
    eng(0, 16'd2, '0);
    idle(3);
    check_cnt("eng_rd");

    // Host held off by five engine cycles, then granted.
    for (int i = 0; i < 5; i++) step(1, 0, 16'(i % 3), '0, 1, 0, 16'd2, '0, 0);
    step(0, 0, '0, '0, 1, 0, 16'd2, '0, 0);
    idle(3);
    check_cnt("conflict");

    // Address aliasing plus read-after-write.
    eng(1, 16'h0405, 32'hABCD);
    eng(0, 16'h0005, '0);
    idle(3);

    // Reset with reads in flight drops them; storage survives.
    eng(0, 16'd0, '0);
    eng(0, 16'd1, '0);
    #1;
    rst_n    = 1'b0;
    mem_req  = 1'b0;
    host_req = 1'b0;
    eq_mem.delete();
    et_mem.delete();
    eq_host.delete();
    et_host.delete();
    m_rd = 0;
    m_wr = 0;
    m_cf = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    check_cnt("after_rst");
    eng(0, 16'd1, '0);
    step(1, 0, 16'd2, '0, 0, 0, '0, '0, 1);
    check_cnt("clr");
    idle(3);

    // Randomized traffic over a small aliased window.
    for (int k = 0; k < 16; k++) hst(1, 16'(k), $urandom);
    hp   = 1'b0;
    hw_r = 1'b0;
    ha_r = '0;
    hd_r = '0;
    for (int i = 0; i < 400; i++) begin
      mr = ($urandom_range(0, 9) < 6);
      if (!hp && $urandom_range(0, 2) == 0) begin
        hp   = 1'b1;
        hw_r = 1'($urandom_range(0, 1));
        ha_r = rand_addr();
        hd_r = $urandom;
      end
      step(mr, 1'($urandom_range(0, 1)), rand_addr(), $urandom, hp, hw_r, ha_r, hd_r,
           ($urandom_range(0, 49) == 0));
      if (hp && !mr) hp = 1'b0;
      if (i % 50 == 49) check_cnt("rand");
    end
    idle(LAT + 2);
    check_cnt("final");

    wait_cnt = 0;
    while ((eq_mem.size() != 0 || eq_host.size() != 0) && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (eq_mem.size() != 0 || eq_host.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d mem and %0d host reads outstanding, required 0", eq_mem.size(),
               eq_host.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
